// File: rtl/playfield_controller.sv
// playfield_controller: registered playfield board plus the lock / line-clear / wipe sequencer.
// Tiles are 3-bit types; 0 is BLANK. Row 0 is the top row.
// Optional build macro PLAYFIELD_COLLISION_CHK_EN: reject locks that touch an occupied or
// off-board cell (no write, straight to DONE with collision=1). Without it, occupied cells are
// overwritten, off-board cells are skipped and collision is tied low.
module playfield_controller #(
  parameter int unsigned ROWS = 20,  // PLAYFIELD_DIM_Y
  parameter int unsigned COLS = 10   // PLAYFIELD_DIM_X
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          lock_valid,
  output logic                          lock_ready,
  input  logic [2:0]                    lock_type,
  input  logic [3:0][4:0]               lock_row,
  input  logic [3:0][3:0]               lock_col,
  input  logic                          game_clear,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    lines_cleared,
  output logic                          collision,
  output logic [ROWS-1:0][COLS-1:0][2:0] tile_type
);

  localparam logic [2:0]    BLANK    = 3'd0;
  localparam int unsigned   RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [5:0]    ROW_LIM  = 6'(ROWS);
  localparam logic [4:0]    COL_LIM  = 5'(COLS);

  typedef enum logic [1:0] {StIdle, StScan, StDone, StWipe} state_t;

  state_t                           state_q, state_d;
  logic [RW-1:0]                    row_q, row_d;     // scan row (counts up in WIPE)
  logic [2:0]                       cnt_q, cnt_d;     // cleared lines, saturating
  logic [ROWS-1:0][COLS-1:0][2:0]   tile_q, tile_d;
  logic                             row_full;

  // Row under the scan pointer is full when no cell in it is BLANK.
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < int'(COLS); c++) begin
      if (tile_q[row_q][c] == BLANK) row_full = 1'b0;
    end
  end

`ifdef PLAYFIELD_COLLISION_CHK_EN
  logic coll_q, coll_d;
  logic lock_hit;

  // A lock collides if any of its cells is off the board or already occupied.
  always_comb begin
    lock_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (({1'b0, lock_row[k]} >= ROW_LIM) || ({1'b0, lock_col[k]} >= COL_LIM)) begin
        lock_hit = 1'b1;
      end else if (tile_q[lock_row[k]][lock_col[k]] != BLANK) begin
        lock_hit = 1'b1;
      end
    end
  end
`endif

  // Next-state, board update and counters.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
`ifdef PLAYFIELD_COLLISION_CHK_EN
    coll_d  = coll_q;
`endif
    unique case (state_q)
      StIdle: begin
        // game_clear wins over a simultaneous lock request
        if (game_clear) begin
          row_d   = '0;
          state_d = StWipe;
        end else if (lock_valid) begin
          cnt_d = '0;
`ifdef PLAYFIELD_COLLISION_CHK_EN
          coll_d = lock_hit;
          if (lock_hit) begin
            state_d = StDone;
          end else begin
`endif
            for (int k = 0; k < 4; k++) begin
              if (({1'b0, lock_row[k]} < ROW_LIM) && ({1'b0, lock_col[k]} < COL_LIM)) begin
                tile_d[lock_row[k]][lock_col[k]] = lock_type;
              end
            end
            row_d   = ROW_LAST;
            state_d = StScan;
`ifdef PLAYFIELD_COLLISION_CHK_EN
          end
`endif
        end
      end
      StScan: begin
        if (row_full) begin
          // Drop rows 0..r-1 onto r..1; row r is rescanned next cycle.
          for (int i = int'(ROWS) - 1; i >= 1; i--) begin
            if (i <= int'(row_q)) tile_d[i] = tile_q[i-1];
          end
          tile_d[0] = '0;
          cnt_d     = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        end else if (row_q == '0) begin
          state_d = StDone;
        end else begin
          row_d = row_q - RW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StWipe: begin
        tile_d[row_q] = '0;
        if (row_q == ROW_LAST) begin
          state_d = StIdle;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and board registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      cnt_q   <= '0;
      tile_q  <= '0;
`ifdef PLAYFIELD_COLLISION_CHK_EN
      coll_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
`ifdef PLAYFIELD_COLLISION_CHK_EN
      coll_q  <= coll_d;
`endif
    end
  end

  assign tile_type     = tile_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign lock_ready    = (state_q == StIdle) && !game_clear;
  assign lines_cleared = done ? cnt_q : 3'd0;
`ifdef PLAYFIELD_COLLISION_CHK_EN
  assign collision     = done ? coll_q : 1'b0;
`else
  assign collision     = 1'b0;
`endif

endmodule

// File: tb/tb_playfield_controller.sv
// Bench for playfield_controller: directed scenarios with literal expectations, then random
// traffic checked every cycle against a board/latency model. Honours PLAYFIELD_COLLISION_CHK_EN.
module tb_playfield_controller;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic                           clk = 1'b0;
  logic                           reset_n = 1'b1;
  logic                           lock_valid = 1'b0;
  logic                           game_clear = 1'b0;
  logic [2:0]                     lock_type = 3'd0;
  logic [3:0][4:0]                lock_row = '0;
  logic [3:0][3:0]                lock_col = '0;
  logic                           lock_ready, busy, done, collision;
  logic [2:0]                     lines_cleared;
  logic [ROWS-1:0][COLS-1:0][2:0] tile_type;

  int checks = 0;
  int failures = 0;

  // Model: final board plus how many cycles the block stays busy for the current operation.
  int board [ROWS][COLS];
  int m_left = 0;
  bit m_is_lock = 1'b0;
  int m_lines = 0;
  bit m_coll = 1'b0;

  playfield_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .lock_type     (lock_type),
    .lock_row      (lock_row),
    .lock_col      (lock_col),
    .game_clear    (game_clear),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .collision     (collision),
    .tile_type     (tile_type)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one accepted lock to the model: write, drop every full row, derive latency.
  task automatic model_lock();
    int nb [ROWS][COLS];
    int dst;
    int ncl;
    bit full;
`ifdef PLAYFIELD_COLLISION_CHK_EN
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (int'(lock_row[k]) >= ROWS || int'(lock_col[k]) >= COLS) hit = 1'b1;
        else if (board[lock_row[k]][lock_col[k]] != 0) hit = 1'b1;
      end
      if (hit) begin
        m_left = 1; m_is_lock = 1'b1; m_lines = 0; m_coll = 1'b1;
        return;
      end
    end
`endif
    for (int k = 0; k < 4; k++) begin
      if (int'(lock_row[k]) < ROWS && int'(lock_col[k]) < COLS)
        board[lock_row[k]][lock_col[k]] = int'(lock_type);
    end
    ncl = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (board[r][c] == 0) full = 1'b0;
      if (full) ncl++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = board[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--) for (int c = 0; c < COLS; c++) nb[r][c] = 0;
    board = nb;
    m_lines = ncl; m_left = ROWS + ncl + 1; m_is_lock = 1'b1; m_coll = 1'b0;
  endtask

  // Model advance on each clock edge, reset asynchronously.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_is_lock = 1'b0; m_lines = 0; m_coll = 1'b0;
      foreach (board[r, c]) board[r][c] = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (game_clear) begin
      foreach (board[r, c]) board[r][c] = 0;
      m_left = ROWS; m_is_lock = 1'b0;
    end else if (lock_valid) begin
      model_lock();
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    bit e_done;
    logic [ROWS-1:0][COLS-1:0][2:0] e_tiles;
    e_done = m_is_lock && (m_left == 1);
    chk("busy", busy, m_left > 0);
    chk("done", done, e_done);
    chk("lines_cleared", lines_cleared, e_done ? m_lines : 0);
    chk("collision", collision, e_done ? m_coll : 0);
    chk("lock_ready", lock_ready, (m_left == 0) && !game_clear);
    if (m_left == 0) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) e_tiles[r][c] = 3'(board[r][c]);
      checks++;
      if (tile_type !== e_tiles) begin
        failures++;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (tile_type[r][c] !== e_tiles[r][c] && e_tiles[r][c] !== 3'bxxx) begin
              $display("FAIL board r%0d c%0d: got %0d expected %0d at t=%0t",
                       r, c, tile_type[r][c], e_tiles[r][c], $time);
              r = ROWS; c = COLS;
            end
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 100) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy got 1 expected 0 after 100 cycles");
    end
  endtask

  task automatic start_lock(input logic [2:0] t, input logic [3:0][4:0] r,
                            input logic [3:0][3:0] c);
    wait_idle();
    @(posedge clk); #2;
    lock_type = t; lock_row = r; lock_col = c; lock_valid = 1'b1;
    @(posedge clk); #2;
    lock_valid = 1'b0;
  endtask

  // Cycle numbers count negedges after the handshake edge; -1 if done never came.
  task automatic wait_done(output int lat, output int ln, output int co);
    lat = -1; ln = -1; co = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; ln = int'(lines_cleared); co = int'(collision);
        return;
      end
    end
  endtask

  task automatic lock_piece(input logic [2:0] t, input logic [3:0][4:0] r,
                            input logic [3:0][3:0] c, output int lat, output int ln,
                            output int co);
    start_lock(t, r, c);
    wait_done(lat, ln, co);
  endtask

  task automatic wipe_with_lock();
    int n;
    int sd;
    wait_idle();
    @(posedge clk); #2;
    game_clear = 1'b1; lock_valid = 1'b1; lock_type = 3'd5;
    lock_row = {4{5'd10}}; lock_col = {4'd3, 4'd2, 4'd1, 4'd0};
    #1 chk("wipe_lock_ready", lock_ready, 0);
    @(posedge clk); #2;
    game_clear = 1'b0; lock_valid = 1'b0;
    n = 0; sd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) sd = 1;
      if (!busy) break;
      n++;
    end
    chk("wipe_busy_cycles", n, 20);
    chk("wipe_no_done", sd, 0);
    chk("wipe_board_blank", tile_type == '0, 1);
  endtask

  initial begin
    int lat, ln, co, r0, c0;

    // Reset
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_board_blank", tile_type == '0, 1);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_lock_ready", lock_ready, 1);

    // T piece, no clear
    lock_piece(3'd6, {5'd18, 5'd19, 5'd19, 5'd19}, {4'd4, 4'd5, 4'd4, 4'd3}, lat, ln, co);
    chk("t_latency", lat, 21);
    chk("t_lines", ln, 0);
    chk("t_cells", (tile_type[19][3] == 3'd6) && (tile_type[19][4] == 3'd6) &&
        (tile_type[19][5] == 3'd6) && (tile_type[18][4] == 3'd6) &&
        (tile_type[18][3] == 3'd0), 1);

    wipe_with_lock();

    // Single clear
    lock_piece(3'd1, {4{5'd19}}, {4'd3, 4'd2, 4'd1, 4'd0}, lat, ln, co);
    chk("i1_latency", lat, 21);
    lock_piece(3'd1, {4{5'd19}}, {4'd7, 4'd6, 4'd5, 4'd4}, lat, ln, co);
    chk("i2_latency", lat, 21);
    lock_piece(3'd4, {5'd19, 5'd19, 5'd18, 5'd18}, {4'd9, 4'd8, 4'd9, 4'd8}, lat, ln, co);
    chk("o_latency", lat, 22);
    chk("o_lines", ln, 1);
    chk("o_row19", (tile_type[19][8] == 3'd4) && (tile_type[19][9] == 3'd4) &&
        (tile_type[19][7:0] == '0), 1);
    chk("o_row18_blank", tile_type[18] == '0, 1);

    wipe_with_lock();

    // Tetris
    for (int c = 0; c < 9; c++) begin
      lock_piece(3'd2, {5'd19, 5'd18, 5'd17, 5'd16}, {4{4'(c)}}, lat, ln, co);
      chk("prefill_latency", lat, 21);
    end
    lock_piece(3'd7, {5'd19, 5'd18, 5'd17, 5'd16}, {4{4'd9}}, lat, ln, co);
    chk("tetris_latency", lat, 25);
    chk("tetris_lines", ln, 4);
    chk("tetris_board_blank", tile_type == '0, 1);

    // Overlapping lock
    lock_piece(3'd1, {4{5'd19}}, {4'd3, 4'd2, 4'd1, 4'd0}, lat, ln, co);
    lock_piece(3'd4, {5'd19, 5'd19, 5'd18, 5'd18}, {4'd3, 4'd2, 4'd3, 4'd2}, lat, ln, co);
`ifdef PLAYFIELD_COLLISION_CHK_EN
    chk("coll_latency", lat, 1);
    chk("coll_flag", co, 1);
    chk("coll_cell_kept", tile_type[19][2], 1);
    chk("coll_no_write", tile_type[18][2], 0);
`else
    chk("overwrite_latency", lat, 21);
    chk("overwrite_flag", co, 0);
    chk("overwrite_cell", tile_type[19][2], 4);
    chk("overwrite_upper", tile_type[18][2], 4);
`endif

    // Reset mid-scan
    start_lock(3'd3, {4{5'd5}}, {4'd3, 4'd2, 4'd1, 4'd0});
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_board_blank", tile_type == '0, 1);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_lock_ready", lock_ready, 1);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #2;
      lock_valid = 1'($urandom_range(0, 1));
      game_clear = ($urandom_range(0, 299) == 0);
      lock_type  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        r0 = $urandom_range(15, 20);
        c0 = $urandom_range(0, 9);
        for (int k = 0; k < 4; k++) begin
          lock_row[k] = 5'(r0);
          lock_col[k] = 4'(c0 + k);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          lock_row[k] = 5'($urandom_range(14, 20));
          lock_col[k] = 4'($urandom_range(0, 10));
        end
      end
    end
    @(posedge clk); #2;
    lock_valid = 1'b0; game_clear = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/playfield_controller.md
PLAYFIELD_CONTROLLER -- requirements
Module: playfield_controller

Interface
REQ-001 SHALL have parameter ROWS, default PLAYFIELD_DIM_Y (20), the number of playfield rows; row 0 is the top row.
REQ-002 SHALL have parameter COLS, default PLAYFIELD_DIM_X (10), the number of playfield columns.
REQ-003 SHALL have port clk  in  1  system clock; the block uses this single clock.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port lock_valid  in  1  piece-lock request.
REQ-006 SHALL have port lock_ready  out  1  lock request accepted when high together with lock_valid.
REQ-007 SHALL have port lock_type  in  tile_type_t  tile type written to all four cells.
REQ-008 SHALL have port lock_row[4]  in  4x5  target rows of the four piece cells.
REQ-009 SHALL have port lock_col[4]  in  4x4  target columns of the four piece cells.
REQ-010 SHALL have port game_clear  in  1  request to wipe the board.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port done  out  1  one-cycle pulse at the end of each lock sequence.
REQ-013 SHALL have port lines_cleared  out  3  count of rows cleared; valid while done is high.
REQ-014 SHALL have port collision  out  1  lock rejected; valid while done is high.
REQ-015 SHALL have port tile_type  out  [ROWS][COLS] tile_type_t  registered board state, fed directly to the PlayfieldPixelDriver.

Function
REQ-016 SHALL implement an FSM with states IDLE, SCAN, DONE and WIPE.
REQ-017 SHALL drive lock_ready = (state==IDLE) && !game_clear.
REQ-018 SHALL give game_clear priority over lock_valid when both are high in the same IDLE cycle; game_clear is sampled only in IDLE.
REQ-019 On a lock handshake edge, SHALL write lock_type to the four cells, load row counter r=ROWS-1, clear the cleared-line count, and enter SCAN.
REQ-020 SHALL silently skip any cell with lock_row>=ROWS or lock_col>=COLS; duplicate cells are harmless.
REQ-021 SHALL accept lock_type==BLANK and erase the four cells with it.
REQ-022 SHALL treat a row as full when all COLS cells in it are non-BLANK.
REQ-023 In each SCAN cycle, if row r is full, SHALL shift rows r..1 down by one at the next edge, set row 0 to BLANK, increment the count (saturating at 7), and keep r unchanged so the row is rescanned.
REQ-024 In each SCAN cycle, if row r is not full, SHALL decrement r; if r==0 and row 0 is not full, SHALL go to DONE.
REQ-025 In DONE, SHALL hold done=1 for one cycle, present lines_cleared and collision, then return to IDLE.
REQ-026 Lock latency: with k rows cleared, done SHALL assert in cycle ROWS+k+1 after the handshake edge.
REQ-027 On game_clear in IDLE, SHALL enter WIPE and BLANK one row per cycle from row 0 to row ROWS-1 (ROWS cycles), then return to IDLE with no done pulse.
REQ-028 SHALL hold lines_cleared and collision at 0 whenever done is low.

Reset
REQ-029 While reset_n is low, SHALL immediately set all tile_type cells to BLANK, state to IDLE, and done, lines_cleared, collision and busy to 0, including when reset hits mid-SCAN or mid-WIPE.
REQ-030 SHALL have lock_ready=1 (given game_clear low) in the first cycle after reset_n is released.

Configuration
REQ-031 With macro PLAYFIELD_COLLISION_CHK_EN defined, SHALL reject a lock at the handshake edge if any cell is out of range or non-BLANK: no cell is written, the FSM goes directly to DONE, and done and collision are 1 in the next cycle.
REQ-032 Without PLAYFIELD_COLLISION_CHK_EN, SHALL overwrite occupied cells, skip out-of-range cells as in REQ-020, and tie collision to 0.

Verification
REQ-033 Reset scenario: assert reset_n=0 -> all 200 cells are BLANK, busy=0, done=0; after release, lock_ready=1.
REQ-034 No-clear scenario: single T lock at rows 18-19, cols 3-5 -> done in cycle 21, lines_cleared=0, four T cells present.
REQ-035 Single-clear scenario: two I locks fill row 19 cols 0-7, then an O lock at rows 18-19, cols 8-9 -> done in cycle 22, lines_cleared=1, row 19 holds O only at cols 8-9.
REQ-036 Tetris scenario: rows 16-19 prefilled at cols 0-8, then a vertical I at col 9 -> done in cycle 25, lines_cleared=4, board all BLANK.
REQ-037 Wipe-priority scenario: game_clear=1 and lock_valid=1 in the same IDLE cycle -> lock_ready=0, busy for 20 cycles, board BLANK, no done, lock not applied.
REQ-038 Collision scenario (macro on): lock overlapping an occupied cell -> done and collision are 1 in the next cycle, board unchanged; with the macro off, the cell is overwritten and collision=0.
